// File: rtl/sdf_stage_ctrl.sv
// Per-stage sequencer for a 256-point SDF FFT: feedback-RAM address/write, butterfly mode,
// and -j select or twiddle exponent. SDF_CTRL_SYNC_CHECK_EN enables in_sof alignment check/resync.
module sdf_stage_ctrl #(
    parameter int LOG_DEPTH = 7,
    parameter int TW_STAGE  = 0
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 in_valid,
    input  logic                 in_sof,
    input  logic                 flush,
    output logic                 in_ready,
    output logic [LOG_DEPTH-1:0] ram_addr,
    output logic                 ram_we,
    output logic                 bf_mode,
    output logic                 out_valid,
    output logic                 mj_sel,
    output logic [LOG_DEPTH+1:0] tw_addr,
    output logic                 sync_err,
    output logic [1:0]           dbg_state
);
    // Handshake: a sample transfers on a rising CLK edge where in_valid & in_ready. in_valid may
    // stay high without a transfer; in_ready is a function of state, wcnt and flush only.

    localparam int CW = LOG_DEPTH + 2;
    localparam logic [CW-1:0] DEPTH     = {2'b01, {LOG_DEPTH{1'b0}}};
    localparam logic [CW-1:0] FILL_LAST = {2'b00, {LOG_DEPTH{1'b1}}};
    localparam logic [CW-1:0] ONE       = {{(CW-1){1'b0}}, 1'b1};

    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [CW-1:0]        wcnt_q, wcnt_d;
    logic                 flush_pend_q, flush_pend_d;
    logic [LOG_DEPTH-1:0] ram_addr_q, ram_addr_d;
    logic                 ram_we_q, ram_we_d;
    logic                 bf_mode_q, bf_mode_d;
    logic                 out_valid_q, out_valid_d;
    logic                 mj_sel_q, mj_sel_d;
    logic [CW-1:0]        tw_addr_q, tw_addr_d;
    logic                 sync_err_q, sync_err_d;

    logic                 boundary, flush_now, accept, resync;
    logic [CW-1:0]        m, n_ext, tw_calc;
    logic [1:0]           quarter;
    logic                 mj_calc;

    always_comb begin
        boundary  = (state_q == ST_RUN) && (wcnt_q[LOG_DEPTH:0] == '0);
        flush_now = boundary && (flush || flush_pend_q);
        in_ready  = (state_q != ST_DRAIN) && !flush_now;
        accept    = in_valid && in_ready;
    end

`ifdef SDF_CTRL_SYNC_CHECK_EN
    logic sof_aligned;
    always_comb begin
        if (TW_STAGE != 0) begin
            sof_aligned = (wcnt_q == '0);
        end else begin
            sof_aligned = (wcnt_q[LOG_DEPTH:0] == '0);
        end
        resync = accept && in_sof && !sof_aligned;
    end
`else
    logic unused_sof;
    assign unused_sof = in_sof;
    assign resync     = 1'b0;
`endif

    // Output position lags the input counter by one delay line.
    always_comb begin
        m       = wcnt_q - DEPTH;
        quarter = m[CW-1:LOG_DEPTH];
        n_ext   = {2'b00, m[LOG_DEPTH-1:0]};
        mj_calc = 1'b0;
        tw_calc = '0;
        if (TW_STAGE == 0) begin
            mj_calc = (m[LOG_DEPTH:LOG_DEPTH-1] == 2'b11);
        end else begin
            case (quarter)
                2'd1:    tw_calc = n_ext << 1;
                2'd2:    tw_calc = n_ext;
                2'd3:    tw_calc = (n_ext << 1) + n_ext;
                default: tw_calc = '0;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        flush_pend_d = flush_pend_q;
        ram_addr_d   = ram_addr_q;
        ram_we_d     = 1'b0;
        bf_mode_d    = 1'b0;
        out_valid_d  = 1'b0;
        mj_sel_d     = 1'b0;
        tw_addr_d    = tw_addr_q;
        sync_err_d   = 1'b0;

        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = wcnt_q[LOG_DEPTH-1:0];
                    tw_addr_d  = '0;
                    wcnt_d     = wcnt_q + ONE;
                    if (wcnt_q == FILL_LAST) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (flush_now) begin
                    // The boundary cycle is itself the first drain slot.
                    ram_addr_d   = wcnt_q[LOG_DEPTH-1:0];
                    out_valid_d  = 1'b1;
                    mj_sel_d     = mj_calc;
                    tw_addr_d    = tw_calc;
                    wcnt_d       = wcnt_q + ONE;
                    flush_pend_d = 1'b0;
                    state_d      = ST_DRAIN;
                end else begin
                    if (flush) begin
                        flush_pend_d = 1'b1;
                    end
                    if (accept) begin
                        ram_we_d    = 1'b1;
                        ram_addr_d  = wcnt_q[LOG_DEPTH-1:0];
                        bf_mode_d   = wcnt_q[LOG_DEPTH];
                        out_valid_d = 1'b1;
                        mj_sel_d    = mj_calc;
                        tw_addr_d   = tw_calc;
                        wcnt_d      = wcnt_q + ONE;
                    end
                end
            end
            ST_DRAIN: begin
                ram_addr_d  = wcnt_q[LOG_DEPTH-1:0];
                out_valid_d = 1'b1;
                mj_sel_d    = mj_calc;
                tw_addr_d   = tw_calc;
                if (wcnt_q[LOG_DEPTH-1:0] == '1) begin
                    state_d = ST_FILL;
                    wcnt_d  = '0;
                end else begin
                    wcnt_d = wcnt_q + ONE;
                end
            end
            default: begin
                state_d = ST_FILL;
                wcnt_d  = '0;
            end
        endcase

        // A misaligned frame start restarts filling; it outranks any pending flush.
        if (resync) begin
            state_d      = ST_FILL;
            wcnt_d       = ONE;
            flush_pend_d = 1'b0;
            ram_addr_d   = '0;
            ram_we_d     = 1'b1;
            bf_mode_d    = 1'b0;
            out_valid_d  = 1'b0;
            mj_sel_d     = 1'b0;
            tw_addr_d    = '0;
            sync_err_d   = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_FILL;
            wcnt_q       <= '0;
            flush_pend_q <= 1'b0;
            ram_addr_q   <= '0;
            ram_we_q     <= 1'b0;
            bf_mode_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            mj_sel_q     <= 1'b0;
            tw_addr_q    <= '0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            flush_pend_q <= flush_pend_d;
            ram_addr_q   <= ram_addr_d;
            ram_we_q     <= ram_we_d;
            bf_mode_q    <= bf_mode_d;
            out_valid_q  <= out_valid_d;
            mj_sel_q     <= mj_sel_d;
            tw_addr_q    <= tw_addr_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign bf_mode   = bf_mode_q;
    assign out_valid = out_valid_q;
    assign mj_sel    = mj_sel_q;
    assign tw_addr   = tw_addr_q;
    assign sync_err  = sync_err_q;
    assign dbg_state = state_q;

endmodule

// File: doc/sdf_stage_ctrl.md
# sdf_stage_ctrl

Sequencing controller for one stage of the 256-point single-path delay-feedback (SDF) FFT pipeline.
- Owns the stage's feedback-RAM address, write enable and butterfly mode.
- Generates either the trivial −j select or the twiddle-ROM address for the sample leaving the stage.
- Instantiated once per stage, between the upstream stage's output and the stage's butterfly/RAM/twiddle datapath, replacing per-stage hand-written counters.

## Interface
Parameters:
- LOG_DEPTH, 7, log2 of feedback delay D (D = 2^LOG_DEPTH; 7..0 for stages 0..7); must be ≥ 1
- TW_STAGE, 0, 0 = trivial −j stage (period P = 2D), 1 = full twiddle stage (P = 4D)

Ports:
- CLK  in  1  stage clock, rising edge only
- RST_N  in  1  asynchronous active-low reset
- in_valid  in  1  upstream sample present
- in_sof  in  1  sample is first of a frame (qualified by in_valid & in_ready)
- flush  in  1  level request to drain stored differences at end of stream
- in_ready  out  1  stage accepts a sample this cycle
- ram_addr  out  LOG_DEPTH  feedback RAM read/write address
- ram_we  out  1  write feedback RAM
- bf_mode  out  1  1 = butterfly (output sum, store difference); 0 = fill/feedback (store input, output RAM)
- out_valid  out  1  datapath output valid
- mj_sel  out  1  multiply output by −j (TW_STAGE=0 only, else 0)
- tw_addr  out  LOG_DEPTH+2  twiddle ROM exponent (TW_STAGE=1 only, else 0)
- sync_err  out  1  one-cycle pulse on misaligned in_sof

## Operation
- Accept = in_valid & in_ready.
- Input counter wcnt: LOG_DEPTH+2 bits, +1 per accept, wraps mod 4D.
- States: FILL (reset state), RUN, DRAIN.
- FILL:
  - Per accept: ram_we=1, bf_mode=0, out_valid=0.
  - The accept with wcnt==D−1 moves to RUN.
- RUN, per accept:
  - ram_addr = wcnt[LOG_DEPTH−1:0], ram_we=1, bf_mode = wcnt[LOG_DEPTH], out_valid=1.
  - Output position m = (wcnt − D) mod 4D; quarter q = m[LOG_DEPTH+1:LOG_DEPTH]; n = m[LOG_DEPTH−1:0].
  - TW_STAGE=0: mj_sel = (m[LOG_DEPTH:LOG_DEPTH−1] == 2'b11).
  - TW_STAGE=1: tw_addr = n × k, with k = 0, 2, 1, 3 for q = 0, 1, 2, 3. Width LOG_DEPTH+2; max 3(D−1) < 4D, no truncation.
- Flush:
  - flush is evaluated in RUN only when wcnt[LOG_DEPTH:0]==0 (2D boundary). Elsewhere it is held pending until the next boundary.
  - At the boundary with flush=1: in_ready=0 that same cycle (combinational), and the state goes to DRAIN.
  - flush in FILL is ignored.
- DRAIN:
  - D internal cycles with ram_we=0, bf_mode=0, out_valid=1; ram_addr/m keep counting.
  - After the D-th cycle: state FILL, wcnt=0.
- Sync check:
  - An accept with in_sof=1 is aligned iff wcnt mod P == 0. This covers FILL with wcnt==0.
  - Misaligned: sync_err=1 for one cycle, state→FILL, the sample is written at address 0, wcnt→1.
  - Aligned in RUN: no state change.
- Stall: in_valid=0 freezes wcnt and state; out_valid=0, ram_we=0.

## Timing
- in_ready is combinational from state/wcnt/flush: 1 except in DRAIN and at a flushing boundary.
- All other outputs are registered, 1-cycle latency. Values in cycle k+1 describe the sample accepted (or drain slot) at edge k; the datapath registers input data once to align.
- Reset (RST_N=0) forces immediately:
  - state FILL, wcnt 0;
  - ram_addr 0, ram_we 0, bf_mode 0, out_valid 0, mj_sel 0, tw_addr 0, sync_err 0, flush pending 0;
  - in_ready 1.
- Reset mid-frame or mid-DRAIN discards everything; the next accept is wcnt 0.
- Simultaneous misaligned in_sof and pending flush: resync wins, pending flush cleared.
- Throughput: one sample per cycle, no bubbles in RUN.

## Configuration
- SDF_CTRL_SYNC_CHECK_EN defined: in_sof alignment check and resync as above.
- Not defined: in_sof ignored, sync_err tied 0, no resync logic.

## Test plan
- LOG_DEPTH=2, TW_STAGE=1, 20 back-to-back samples:
  - first out_valid at cycle 5;
  - bf_mode 1 for accepts 4–7 and 12–15;
  - tw_addr for m=5 is 2, m=11 is 3, m=15 is 9.
- LOG_DEPTH=2, TW_STAGE=0, continuous stream: mj_sel=1 exactly for m=6,7 of each 8-sample period.
- Random in_valid gaps (30% idle): ram_addr/tw_addr sequence identical to gapless run; ram_we=out_valid=0 on idle cycles.
- flush asserted at wcnt=5 (D=4): in_ready stays 1 until wcnt=8, then 0 for 4 cycles; 4 drain outputs with bf_mode=0; then FILL, wcnt=0.
- in_sof at wcnt=3 in RUN (macro on): sync_err pulses once, next output after 4 new accepts. With the macro off: no pulse, stream unaffected.
- RST_N pulled low mid-DRAIN: all outputs 0, in_ready 1 immediately; after release, first out_valid after D accepts.
